// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op encodings, FSM states and counter sizing for seq_muldiv.
package muldiv_pkg;
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction
endpackage

// File: rtl/muldiv_abs.sv
// muldiv_abs: conditional two's-complement negate, used for magnitudes and sign fix-up.
module muldiv_abs #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_val,
    input  logic             i_neg,
    output logic [WIDTH-1:0] o_val
);
    assign o_val = i_neg ? -i_val : i_val;
endmodule

// File: rtl/seq_muldiv.sv
// seq_muldiv: multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO unit with HI/LO registers.
// Define MULDIV_EARLY_OUT_EN to let multiplies finish once the multiplier is exhausted.
module seq_muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             n,
    output logic             zout,
    output logic             dz
);
    localparam int CW = cnt_w(WIDTH);

    state_t             r_state, w_next;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc, r_x;
    logic [WIDTH-1:0]   r_y, r_hi, r_lo;
    logic               r_div, r_sq, r_sr, r_done, r_dz;
    logic               w_sgn, w_mt, w_dz0, w_iter, w_last;
    logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_quo, w_rem;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH:0]     w_rs, w_diff;

    assign w_sgn  = ~op[0];
    assign w_mt   = op[2:1] == 2'b10;
    assign w_dz0  = !op[2] && op[1] && b == '0;
    assign w_iter = !op[2] && !w_dz0;

    muldiv_abs #(.WIDTH(WIDTH)) u_abs_a (.i_val(a), .i_neg(w_sgn & a[WIDTH-1]), .o_val(w_abs_a));
    muldiv_abs #(.WIDTH(WIDTH)) u_abs_b (.i_val(b), .i_neg(w_sgn & b[WIDTH-1]), .o_val(w_abs_b));
    muldiv_abs #(.WIDTH(2*WIDTH)) u_fix_p (.i_val(r_acc), .i_neg(r_sq), .o_val(w_prod));
    muldiv_abs #(.WIDTH(WIDTH)) u_fix_q (.i_val(r_y), .i_neg(r_sq), .o_val(w_quo));
    muldiv_abs #(.WIDTH(WIDTH)) u_fix_r (.i_val(r_acc[WIDTH-1:0]), .i_neg(r_sr), .o_val(w_rem));

    // Restoring divide: shift next dividend bit into the partial remainder and trial-subtract.
    assign w_rs   = {r_acc[WIDTH-1:0], r_y[WIDTH-1]};
    assign w_diff = w_rs - {1'b0, r_x[WIDTH-1:0]};

`ifdef MULDIV_EARLY_OUT_EN
    assign w_last = r_cnt == '0 || (!r_div && r_y[WIDTH-1:1] == '0);
`else
    assign w_last = r_cnt == '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_next = r_state == IDLE ? ((start && w_iter) ? CALC : IDLE) :
                 r_state == CALC ? (w_last ? FIX : CALC) : IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
            r_dz   <= 1'b0;
            r_cnt  <= '0;
            r_acc  <= '0;
            r_x    <= '0;
            r_y    <= '0;
            r_div  <= 1'b0;
            r_sq   <= 1'b0;
            r_sr   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == IDLE && start) begin
                if (w_mt) begin
                    if (op[0]) r_lo <= a;
                    else       r_hi <= a;
                    r_done <= 1'b1;
                end else if (w_dz0) begin
                    r_hi   <= a;
                    r_lo   <= '1;
                    r_dz   <= 1'b1;
                    r_done <= 1'b1;
                end else if (w_iter) begin
                    r_div <= op[1];
                    r_sq  <= w_sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                    r_sr  <= w_sgn & a[WIDTH-1];
                    r_acc <= '0;
                    r_x   <= {{WIDTH{1'b0}}, op[1] ? w_abs_b : w_abs_a};
                    r_y   <= op[1] ? w_abs_a : w_abs_b;
                    r_cnt <= CW'(WIDTH - 1);
                end
            end else if (r_state == CALC) begin
                r_cnt <= r_cnt - 1'b1;
                if (r_div) begin
                    r_acc <= {{WIDTH{1'b0}}, w_diff[WIDTH] ? w_rs[WIDTH-1:0] : w_diff[WIDTH-1:0]};
                    r_y   <= {r_y[WIDTH-2:0], ~w_diff[WIDTH]};
                end else begin
                    r_acc <= r_acc + (r_y[0] ? r_x : '0);
                    r_x   <= r_x << 1;
                    r_y   <= r_y >> 1;
                end
            end else if (r_state == FIX) begin
                r_hi   <= r_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
                r_lo   <= r_div ? w_quo : w_prod[WIDTH-1:0];
                r_done <= 1'b1;
                if (r_div) r_dz <= 1'b0;
            end
        end
    end

    assign busy = r_state != IDLE;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;
    assign n    = r_hi[WIDTH-1];
    assign zout = r_hi == '0 && r_lo == '0;
    assign dz   = r_dz;
endmodule
